// File: rtl/seq_scan_ctrl.sv
// Sequences a serial 3-bit overlapping Mealy pattern detector over WIDTH-bit words,
// shifting each word MSB-first and returning a hit count plus a per-bit hit map.
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_pattern,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             match,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic [WIDTH-1:0] hit_map
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0]    K_LAST  = KW'(WIDTH - 1);
  localparam logic [KW-1:0]    K_FIRST = KW'(2);
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] map_q, map_d;
  logic [2:0]       pat_q, pat_d;
  logic [1:0]       hist_q, hist_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    hist_d    = hist_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    map_d     = map_q;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    match     = 1'b0;
    out_valid = 1'b0;
    ser_bit   = shreg_q[WIDTH-1];

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d = in_data;
          pat_d   = in_pattern;
          hist_d  = '0;
          k_d     = '0;
          cnt_d   = '0;
          map_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        // History is cleared per word, so the first two bits can never complete a hit.
        match   = (k_q >= K_FIRST) && ({hist_q, ser_bit} == pat_q);
        hist_d  = {hist_q[0], ser_bit};
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        k_d     = k_q + 1'b1;
        if (match) begin
          cnt_d = cnt_q + 1'b1;
          map_d = map_q | (MSB_ONE >> k_q);
        end
        if (k_q == K_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hist_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      map_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      map_q   <= map_d;
    end
  end

  // Word and pattern are pure data; they are always reloaded before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    pat_q   <= pat_d;
  end

  assign hit_count = cnt_q;
  assign hit_map   = map_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: driver pushes model expectations into queues,
// a negedge monitor pops and compares serial bits, match flags and results.
module tb_seq_scan_ctrl;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk, reset, in_valid, in_ready, ser_bit, ser_valid, match;
  logic          out_valid, out_ready;
  logic [W-1:0]  in_data, hit_map;
  logic [2:0]    in_pattern;
  logic [CW-1:0] hit_count;

  seq_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_pattern(in_pattern), .ser_bit(ser_bit),
    .ser_valid(ser_valid), .match(match), .out_valid(out_valid),
    .out_ready(out_ready), .hit_count(hit_count), .hit_map(hit_map)
  );

  typedef struct {
    int           cnt;
    logic [W-1:0] map;
    int           acc;
  } res_t;

  res_t       rq[$];
  logic [1:0] mq[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         rnd_or = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference: for each bit position i of the MSB-first stream, a hit means the
  // three most recent bits of this word equal the pattern (oldest first).
  function automatic void model(input logic [W-1:0] d, input logic [2:0] p,
                                output int cnt, output logic [W-1:0] map,
                                output logic [1:0] bits[W]);
    logic b[W];
    logic m;
    for (int i = 0; i < W; i++) b[i] = d[W-1-i];
    cnt = 0;
    map = '0;
    for (int i = 0; i < W; i++) begin
      m = (i >= 2) && (b[i-2] == p[2]) && (b[i-1] == p[1]) && (b[i] == p[0]);
      bits[i] = {b[i], m};
      if (m) begin
        cnt++;
        map[W-1-i] = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_or) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic [2:0] p,
                           input bit use_exp, input int ecnt, input logic [W-1:0] emap,
                           input bit hold, output int acc);
    int           n, mcnt;
    logic [W-1:0] mmap;
    logic [1:0]   bits[W];
    res_t         r;
    in_data    = d;
    in_pattern = p;
    in_valid   = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    model(d, p, mcnt, mmap, bits);
    for (int i = 0; i < W; i++) mq.push_back(bits[i]);
    r.cnt = use_exp ? ecnt : mcnt;
    r.map = use_exp ? emap : mmap;
    r.acc = cyc + 1;
    rq.push_back(r);
    acc = cyc + 1;
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || !in_ready) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) fail_now("drain_timeout");
  endtask

  // Monitor: decoupled from the driver, samples on the falling edge.
  initial begin
    logic [1:0] e;
    res_t       r;
    bit         prev_ov = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ser_valid) begin
          if (mq.size() == 0) fail_now("unexpected_ser_valid");
          else begin
            e = mq.pop_front();
            chk("ser_bit", 32'(ser_bit), 32'(e[1]));
            chk("match", 32'(match), 32'(e[0]));
          end
        end
        if (out_valid && !prev_ov && rq.size() != 0)
          chk("out_latency", 32'(cyc - rq[0].acc), 32'(W));
        if (out_valid && out_ready) begin
          if (rq.size() == 0) fail_now("unexpected_result");
          else begin
            r = rq.pop_front();
            chk("hit_count", 32'(hit_count), 32'(r.cnt));
            chk("hit_map", 32'(hit_map), 32'(r.map));
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    int a1, a2, n;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_pattern = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ser_valid", 32'(ser_valid), 0);
    chk("rst_match", 32'(match), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_hit_map", 32'(hit_map), 0);
    reset = 1'b0;
    tick();

    // Directed words with literal expectations
    send_word(8'b10101101, 3'b101, 1, 3, 8'b00101001, 0, a1); drain();
    send_word(8'hFF, 3'b111, 1, 6, 8'b00111111, 0, a1);       drain();
    send_word(8'h00, 3'b000, 1, 6, 8'b00111111, 0, a1);       drain();
    send_word(8'b00000101, 3'b101, 1, 1, 8'b00000001, 0, a1); drain();
    send_word(8'b01000000, 3'b101, 1, 0, 8'b00000000, 0, a1); drain();

    // Back-pressure in DONE while in_valid pulses
    out_ready = 1'b0;
    send_word(8'b11011011, 3'b011, 1, 2, 8'b00001001, 0, a1);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (!out_valid) fail_now("bp_out_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_data  = W'($urandom);
      tick();
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_hit_count", 32'(hit_count), 2);
      chk("bp_hit_map", 32'(hit_map), 32'(8'b00001001));
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", 32'(in_ready), 1);
    chk("bp_release_out_valid", 32'(out_valid), 0);

    // Reset in the middle of a scan
    send_word(8'b10101101, 3'b101, 1, 3, 8'b00101001, 0, a1);
    tick(); tick(); tick();
    reset = 1'b1;
    mq.delete();
    rq.delete();
    tick();
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_ser_valid", 32'(ser_valid), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_hit_count", 32'(hit_count), 0);
    chk("midrst_hit_map", 32'(hit_map), 0);
    reset = 1'b0;
    send_word(8'b10101101, 3'b101, 1, 3, 8'b00101001, 0, a1); drain();

    // in_valid held high across two words
    send_word(8'b11100111, 3'b110, 0, 0, '0, 1, a1);
    send_word(8'b01101101, 3'b011, 0, 0, '0, 1, a2);
    in_valid = 1'b0;
    chk("accept_spacing", 32'(a2 - a1), 32'(W + 2));
    drain();

    // Randomised words with random consumer back-pressure
    rnd_or = 1;
    for (int i = 0; i < 40; i++)
      send_word(W'($urandom), 3'($urandom_range(0, 7)), 0, 0, '0, 0, a1);
    drain();
    rnd_or = 0;
    out_ready = 1'b1;
    drain();
    tick(); tick();
    chk("results_left", 32'(rq.size()), 0);
    chk("bits_left", 32'(mq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
